// File: rtl/count_wrap_pkg.sv
// count_wrap_pkg
//   Shared types and constants for the count_wrap_stopwatch block.
//   state_t        : stopwatch control states
//   WRAP_VALUE_DEF : default terminal count of the upstream counter
//   BCD_NINE/BCD_59: BCD rollover points for the mm:ss digits
package count_wrap_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [15:0] WRAP_VALUE_DEF = 16'hEA60;
  localparam logic [3:0]  BCD_NINE       = 4'h9;
  localparam logic [7:0]  BCD_59         = 8'h59;

endpackage

// File: rtl/count_wrap_stopwatch_bcd.sv
// bcd_mod60_counter
//   Two-digit BCD counter, 00..59, used for both seconds and minutes.
//   Ports:
//     clk    in   clock
//     n_rst  in   async active-low reset
//     clr    in   synchronous zero; wins over inc
//     inc    in   advance by one this cycle
//     value  out  [7:0] current BCD value
//     carry  out  high in the cycle a 59->00 advance is committed; it lets the
//                 next stage advance on the same clock edge
module bcd_mod60_counter
  import count_wrap_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] value,
  output logic       carry
);

  assign carry = inc && !clr && (value == BCD_59);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      value <= 8'h00;
    end else if (clr) begin
      value <= 8'h00;
    end else if (inc) begin
      if (value == BCD_59)
        value <= 8'h00;
      else if (value[3:0] == BCD_NINE)
        value <= {value[7:4] + 4'd1, 4'd0};
      else
        value <= {value[7:4], value[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/count_wrap_stopwatch.sv
// count_wrap_stopwatch
//   Watches a range-limited up-counter (0..WRAP_VALUE, then 0), turns each
//   legal wrap into a tick, and accumulates ticks into a BCD mm:ss stopwatch.
//   Any out-of-range value or illegal step latches FAULT until clear.
//   Optional lap capture is built when COUNT_WRAP_LAP_EN is defined.
//   Ports:
//     clk, n_rst        clock, async active-low reset
//     count_in [15:0]   upstream counter value
//     start/stop/clear  level commands (priority clear > bad > stop > start)
//     lap               (COUNT_WRAP_LAP_EN) capture current time in RUN/PAUSE
//     lap_sec_bcd/lap_min_bcd (COUNT_WRAP_LAP_EN) captured time
//     tick              one-cycle pulse per legal wrap (not in FAULT)
//     sec_bcd/min_bcd   BCD time
//     hour_pulse        one-cycle pulse on 59:59 -> 00:00
//     running           state is RUN
//     range_err         state is FAULT
//
//   state | meaning
//   IDLE  | stopped, time held (reset state)
//   RUN   | wraps advance the time
//   PAUSE | stopped, ticks still reported
//   FAULT | illegal count seen; waits for clear
module count_wrap_stopwatch
  import count_wrap_pkg::*;
#(
  parameter logic [15:0] WRAP_VALUE = WRAP_VALUE_DEF
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [15:0] count_in,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
`ifdef COUNT_WRAP_LAP_EN
  input  logic        lap,
  output logic [7:0]  lap_sec_bcd,
  output logic [7:0]  lap_min_bcd,
`endif
  output logic        tick,
  output logic [7:0]  sec_bcd,
  output logic [7:0]  min_bcd,
  output logic        hour_pulse,
  output logic        running,
  output logic        range_err
);

  state_t      state, state_nxt;
  logic [15:0] prev_count;
  logic [16:0] prev_inc;
  logic        wrap, step_ok, bad;
  logic        sec_inc, sec_carry, min_carry;

  // A zero that is not a wrap is an upstream resync: legal, so it is simply
  // excluded from bad and produces no tick.
  assign prev_inc = {1'b0, prev_count} + 17'd1;
  assign wrap     = (prev_count == WRAP_VALUE) && (count_in == 16'd0);
  assign step_ok  = ({1'b0, count_in} == prev_inc) && (count_in <= WRAP_VALUE);
  assign bad      = (count_in > WRAP_VALUE) || ((count_in != 16'd0) && !step_ok);

  // Advance uses the current state, so a start coinciding with a wrap does
  // not count it, while a coinciding stop does.
  assign sec_inc = wrap && (state == RUN);

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else if (bad && state != FAULT) begin
      state_nxt = FAULT;
    end else begin
      case (state)
        IDLE:    if (start && !stop) state_nxt = RUN;
        RUN:     if (stop) state_nxt = PAUSE;
        PAUSE:   if (start && !stop) state_nxt = RUN;
        FAULT:   state_nxt = FAULT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      prev_count <= 16'd0;
      tick       <= 1'b0;
      hour_pulse <= 1'b0;
      running    <= 1'b0;
      range_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      prev_count <= count_in;
      tick       <= wrap && (state != FAULT);
      hour_pulse <= min_carry;
      running    <= (state_nxt == RUN);
      range_err  <= (state_nxt == FAULT);
    end
  end

  bcd_mod60_counter u_sec (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (clear),
    .inc   (sec_inc),
    .value (sec_bcd),
    .carry (sec_carry)
  );

  bcd_mod60_counter u_min (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (clear),
    .inc   (sec_carry),
    .value (min_bcd),
    .carry (min_carry)
  );

`ifdef COUNT_WRAP_LAP_EN
  // Captures the pre-increment time when lap coincides with a wrap.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      lap_sec_bcd <= 8'h00;
      lap_min_bcd <= 8'h00;
    end else if (clear) begin
      lap_sec_bcd <= 8'h00;
      lap_min_bcd <= 8'h00;
    end else if (lap && (state == RUN || state == PAUSE)) begin
      lap_sec_bcd <= sec_bcd;
      lap_min_bcd <= min_bcd;
    end
  end
`endif

endmodule

// File: doc/count_wrap_stopwatch.md
# count_wrap_stopwatch

Downstream consumer of the 16-bit range-limited up-counter, which counts 0..0xEA60 and wraps to 0. It watches the counter value, turns each legal wrap into a one-cycle tick, and accumulates ticks into a BCD mm:ss stopwatch with start/stop/clear control. It also range-checks the incoming count and latches a fault on any illegal value or step.

## Interface
Parameters:
- WRAP_VALUE, 16'hEA60, terminal count of the upstream counter; a legal wrap is WRAP_VALUE followed by 0.

Ports:
- clk  in  1  clock; all state on rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- count_in  in  16  upstream counter value, sampled every cycle.
- start  in  1  level, sampled each cycle: enter RUN.
- stop  in  1  level, sampled each cycle: enter PAUSE.
- clear  in  1  level, sampled each cycle: zero the time, clear the fault, enter IDLE.
- tick  out  1  one-cycle pulse per legal wrap.
- sec_bcd  out  8  seconds, two BCD digits, 00..59.
- min_bcd  out  8  minutes, two BCD digits, 00..59.
- hour_pulse  out  1  one-cycle pulse when the time rolls over from 59:59 to 00:00.
- running  out  1  high while in RUN.
- range_err  out  1  sticky; high while in FAULT.

## Operation
- prev_count register: holds the last sampled count_in. Reset value 0.
- Events, evaluated each cycle from prev_count and count_in:
  - wrap: prev_count == WRAP_VALUE and count_in == 0.
  - resync: count_in == 0 and not a wrap. This is upstream reset or disable. No tick, no error.
  - step_ok: count_in == prev_count + 1 and count_in <= WRAP_VALUE.
  - bad: count_in > WRAP_VALUE, or count_in nonzero and not step_ok. This covers a nonzero hold, a skip and a backward jump.
- FSM states: IDLE (reset state), RUN, PAUSE, FAULT.
- Command priority: clear > bad > stop > start.
  - clear, from any state: go to IDLE and zero the time.
  - bad, from any state except FAULT: go to FAULT.
  - IDLE: start goes to RUN.
  - RUN: stop goes to PAUSE.
  - PAUSE: start goes to RUN.
  - FAULT: exits only on clear.
- tick fires on a wrap in IDLE, RUN or PAUSE. It does not fire in FAULT.
- Time advances by one second only on a wrap while the current state is RUN.
- Seconds rollover: 59 goes to 00 and minutes increment.
- Minutes rollover: 59:59 goes to 00:00 and hour_pulse fires.
- BCD arithmetic: the low digit counts 0..9. The high digit increments when the low digit rolls over. Non-BCD values are unreachable.

## Timing
- Reset values: all outputs 0, state IDLE, prev_count 0.
- Latency: tick, the time update and hour_pulse are registered. They appear one cycle after the cycle in which the 0 that completes the wrap is sampled.
- running and range_err reflect the state register, so they change one cycle after the triggering input.
- Wrap in the same cycle as start, state IDLE or PAUSE: tick fires, the time does not advance.
- Wrap in the same cycle as stop, state RUN: the time advances.
- Wrap in the same cycle as clear: the time becomes 00:00, tick still fires, hour_pulse is suppressed.
- bad in the same cycle as a wrap cannot occur, because the conditions are exclusive.
- Reset asserted mid-operation: immediate return to the reset values, asynchronously.

## Configuration
- COUNT_WRAP_LAP_EN defined:
  - Adds input lap (1 bit) and outputs lap_sec_bcd and lap_min_bcd (8 bits each).
  - lap high in RUN or PAUSE captures the current sec_bcd/min_bcd, i.e. the value before any same-edge increment.
  - clear zeros the lap registers. Their reset value is 0.
- COUNT_WRAP_LAP_EN undefined: the lap port and the lap registers are absent.

## Structure
- Shared package count_wrap_pkg contains:
  - the state enum (IDLE, RUN, PAUSE, FAULT);
  - the default WRAP_VALUE constant 16'hEA60;
  - BCD constants for 9 and 59.
- Sub-module bcd_mod60_counter, instantiated twice (seconds and minutes).
  - Ports: clk, n_rst, clr, inc → value[7:0], carry.
  - Function: two-digit BCD counter, 00..59, with a carry pulse on the 59→00 transition.

## Test plan
- Drive a legal sequence 0..0xEA60, 0, with start asserted first: tick fires once, sec_bcd = 8'h01.
- Run 3600 wraps in RUN: min_bcd/sec_bcd go 59:59 → 00:00 and hour_pulse fires once on that cycle.
- Assert stop, then drive 5 wraps: tick fires 5 times, time unchanged. Assert start, then 1 wrap: seconds +1.
- Drive count_in 0x0010 then 0x0012: range_err rises the next cycle and later wraps are ignored. Assert clear: IDLE, 00:00, range_err 0.
- Drive count_in = 0xEA61: FAULT. Drive count_in = 0 from 0x1234 (resync): no tick, no error.
- With COUNT_WRAP_LAP_EN: at 00:07, lap coincident with a wrap → lap_sec_bcd = 8'h07 and sec_bcd = 8'h08.
